// File: rtl/riscv_bp_pkg.sv
// Shared branch-predictor types: PCSrc encodings and the BTB training packet.
package riscv_bp_pkg;

   localparam int BP_PC_W = 8;

   localparam logic [1:0] PCSRC_NONE = 2'b00;
   localparam logic [1:0] PCSRC_BR   = 2'b01;
   localparam logic [1:0] PCSRC_JAL  = 2'b10;
   localparam logic [1:0] PCSRC_JALR = 2'b11;

   typedef struct packed {
      logic [BP_PC_W-1:0] pc;
      logic [BP_PC_W-1:0] target;
      logic               taken;
      logic               hit;
   } bp_update_t;

   // Conditional branches follow the ALU flag; jal/jalr are always taken.
   function automatic logic resolve_taken(input logic [1:0] kind, input logic cond);
      return (kind == PCSRC_BR) ? cond : kind[1];
   endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// BTB training channel: resolve unit produces packets, BTB write port consumes them.
interface branch_resolve_unit_if #(
   parameter int PC_W = riscv_bp_pkg::BP_PC_W
);
   logic            upd_valid;
   logic            upd_ready;
   logic [PC_W-1:0] upd_pc;
   logic [PC_W-1:0] upd_target;
   logic            upd_taken;
   logic            upd_hit;

   modport master (
      output upd_valid, upd_pc, upd_target, upd_taken, upd_hit,
      input  upd_ready
   );

   modport slave (
      input  upd_valid, upd_pc, upd_target, upd_taken, upd_hit,
      output upd_ready
   );
endinterface

// File: rtl/btb_update_fifo.sv
// Small power-of-two FIFO for BTB training packets; a full FIFO still accepts a push paired with a pop.
module btb_update_fifo #(
   parameter int W     = 18,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [AW:0]             count;
   logic                    do_pop;
   logic                    do_push;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries prediction metadata IF->ID->EX, resolves it against the real outcome,
// redirects fetch on mispredict and queues BTB training packets.
module branch_resolve_unit
   import riscv_bp_pkg::*;
#(
   parameter int PC_W    = BP_PC_W,
   parameter int Q_DEPTH = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [PC_W-1:0]  if_pc,
   input  logic             if_pred_taken,
   input  logic [PC_W-1:0]  if_pred_target,
   input  logic             if_btb_hit,
   input  logic             stall,
   input  logic [1:0]       ex_kind,
   input  logic             ex_cond,
   input  logic [PC_W-1:0]  ex_target,
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             flush,
   branch_resolve_unit_if.master upd,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] pc;
      logic            pred_taken;
      logic [PC_W-1:0] pred_target;
      logic            hit;
   } meta_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] target;
      logic            taken;
      logic            hit;
   } upd_t;

   meta_t           if_meta;
   meta_t           id_q;
   meta_t           ex_q;
   logic            resolve;
   logic            is_branch;
   logic            act_tk;
   logic            mispred;
   logic [PC_W-1:0] fall;
   logic [PC_W-1:0] act_next;
   logic [PC_W-1:0] pred_next;
   logic            push;
   logic            pop;
   logic            q_full;
   logic            q_empty;
   logic            drop;
   upd_t            pkt;
   upd_t            head;

   assign if_meta = '{valid: if_valid, pc: if_pc, pred_taken: if_pred_taken,
                      pred_target: if_pred_target, hit: if_btb_hit};

   // A stalled EX instruction is resolved only once, on the cycle the stall lifts.
   assign resolve   = ex_q.valid & ~stall;
   assign is_branch = (ex_kind != PCSRC_NONE);
   assign act_tk    = resolve_taken(ex_kind, ex_cond);
   assign fall      = ex_q.pc + PC_W'(1);
   assign act_next  = act_tk ? ex_target : fall;
   assign pred_next = ex_q.pred_taken ? ex_q.pred_target : fall;

   // Comparing next-PCs catches wrong direction, wrong jalr target and aliased non-branches.
   assign mispred        = resolve & (act_next != pred_next) & ~rst;
   assign redirect_valid = mispred;
   assign flush          = mispred;
   assign redirect_pc    = mispred ? act_next : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         id_q <= '0;
         ex_q <= '0;
      end else if (!stall) begin
         id_q <= flush ? '0 : if_meta;
         ex_q <= flush ? '0 : id_q;
      end
   end

   // Non-branch BTB hits still train (taken=0) so the aliased entry decays.
   assign push = resolve & (is_branch | ex_q.hit) & ~rst;
   assign pkt  = '{pc: ex_q.pc, target: ex_target, taken: act_tk, hit: ex_q.hit};
   assign pop  = ~q_empty & upd.upd_ready;
   assign drop = push & q_full & ~pop;

   btb_update_fifo #(
      .W     ($bits(upd_t)),
      .DEPTH (Q_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (pkt),
      .pop   (pop),
      .dout  (head),
      .full  (q_full),
      .empty (q_empty)
   );

   assign upd.upd_valid  = ~q_empty;
   assign upd.upd_pc     = head.pc;
   assign upd.upd_target = head.target;
   assign upd.upd_taken  = head.taken;
   assign upd.upd_hit    = head.hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
         drop_cnt    <= '0;
      end else begin
         if (resolve && is_branch && branch_cnt != '1)
            branch_cnt <= branch_cnt + CNT_W'(1);
         if (mispred && mispred_cnt != '1)
            mispred_cnt <= mispred_cnt + CNT_W'(1);
         if (drop && drop_cnt != '1)
            drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with an instruction-level reference model checked every cycle.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_valid = 1'b0;
   logic [7:0]  if_pc = '0;
   logic        if_pred_taken = 1'b0;
   logic [7:0]  if_pred_target = '0;
   logic        if_btb_hit = 1'b0;
   logic        stall = 1'b0;
   logic [1:0]  ex_kind = '0;
   logic        ex_cond = 1'b0;
   logic [7:0]  ex_target = '0;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        flush;
   logic [15:0] branch_cnt;
   logic [15:0] mispred_cnt;
   logic [15:0] drop_cnt;

   branch_resolve_unit_if #(.PC_W(8)) upd_bus ();

   branch_resolve_unit #(.PC_W(8), .Q_DEPTH(2), .CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_pred_taken  (if_pred_taken),
      .if_pred_target (if_pred_target),
      .if_btb_hit     (if_btb_hit),
      .stall          (stall),
      .ex_kind        (ex_kind),
      .ex_cond        (ex_cond),
      .ex_target      (ex_target),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .upd            (upd_bus.master),
      .branch_cnt     (branch_cnt),
      .mispred_cnt    (mispred_cnt),
      .drop_cnt       (drop_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: one instruction record per pipeline slot, a packet queue, integer counters.
   typedef struct {
      bit         v;
      logic [7:0] pc;
      logic [7:0] ptg;
      logic       pt;
      logic       hit;
   } ins_t;

   typedef struct {
      logic [7:0] pc;
      logic [7:0] tgt;
      logic       tk;
      logic       hit;
   } pkt_t;

   ins_t m_id;
   ins_t m_ex;
   pkt_t q[$];
   int   m_br = 0;
   int   m_mis = 0;
   int   m_drop = 0;
   bit   armed = 0;

   initial forever begin : model
      logic       tk, mis, res, push, pop;
      logic [7:0] fall, an, pn;
      @(negedge clk);
      res  = m_ex.v && !stall;
      tk   = (ex_kind == 2'b01) ? ex_cond : (ex_kind >= 2'b10);
      fall = m_ex.pc + 8'd1;
      an   = tk ? ex_target : fall;
      pn   = m_ex.pt ? m_ex.ptg : fall;
      mis  = res && (an != pn) && !rst;
      if (armed) begin
         chk("m_redirect_valid", redirect_valid, mis);
         chk("m_flush", flush, mis);
         chk("m_redirect_pc", redirect_pc, mis ? an : 8'd0);
         chk("m_upd_valid", upd_bus.upd_valid, q.size() != 0);
         chk("m_upd_pc", upd_bus.upd_pc, q.size() != 0 ? q[0].pc : 8'd0);
         chk("m_upd_target", upd_bus.upd_target, q.size() != 0 ? q[0].tgt : 8'd0);
         chk("m_upd_taken", upd_bus.upd_taken, q.size() != 0 ? q[0].tk : 1'b0);
         chk("m_upd_hit", upd_bus.upd_hit, q.size() != 0 ? q[0].hit : 1'b0);
         chk("m_branch_cnt", branch_cnt, m_br);
         chk("m_mispred_cnt", mispred_cnt, m_mis);
         chk("m_drop_cnt", drop_cnt, m_drop);
      end
      if (rst) begin
         armed = 1;
         m_id = '{v: 0, pc: 0, ptg: 0, pt: 0, hit: 0};
         m_ex = m_id;
         q.delete();
         m_br = 0; m_mis = 0; m_drop = 0;
      end else begin
         pop  = (q.size() != 0) && upd_bus.upd_ready;
         push = res && (ex_kind != 2'b00 || m_ex.hit);
         if (pop) void'(q.pop_front());
         if (push) begin
            if (q.size() < 2) q.push_back('{pc: m_ex.pc, tgt: ex_target, tk: tk, hit: m_ex.hit});
            else m_drop++;
         end
         if (res && ex_kind != 2'b00) m_br++;
         if (mis) m_mis++;
         if (!stall) begin
            if (mis) begin
               m_ex = '{v: 0, pc: 0, ptg: 0, pt: 0, hit: 0};
               m_id = m_ex;
            end else begin
               m_ex = m_id;
               m_id = '{v: if_valid, pc: if_pc, ptg: if_pred_target, pt: if_pred_taken, hit: if_btb_hit};
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [7:0] pc, input logic pt, input logic [7:0] ptg, input logic hit);
      if_valid = 1'b1; if_pc = pc; if_pred_taken = pt; if_pred_target = ptg; if_btb_hit = hit;
   endtask

   task automatic nofetch;
      if_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0; if_pred_target = '0; if_btb_hit = 1'b0;
   endtask

   task automatic exin(input logic [1:0] k, input logic c, input logic [7:0] t);
      ex_kind = k; ex_cond = c; ex_target = t;
   endtask

   // Fetch one instruction, let it reach EX, drive its outcome and settle.
   task automatic issue(input logic [7:0] pc, input logic pt, input logic [7:0] ptg, input logic hit,
                        input logic [1:0] k, input logic c, input logic [7:0] t);
      fetch(pc, pt, ptg, hit); tick;
      nofetch; tick;
      exin(k, c, t); #2;
   endtask

   initial begin
      upd_bus.upd_ready = 1'b1;
      tick; tick;
      rst = 1'b0; #2;
      chk("rst_upd_valid", upd_bus.upd_valid, 0);
      chk("rst_redirect", redirect_valid, 0);
      chk("rst_branch_cnt", branch_cnt, 0);

      // BEQ predicted NT but taken; the instruction behind it must be squashed.
      fetch(8'h10, 0, 8'h00, 0); tick;
      fetch(8'h11, 1, 8'h50, 1); tick;
      nofetch; exin(2'b01, 1, 8'h20); #2;
      chk("t1_redirect_valid", redirect_valid, 1);
      chk("t1_redirect_pc", redirect_pc, 8'h20);
      chk("t1_flush", flush, 1);
      tick; exin(2'b00, 0, 8'h00); #2;
      chk("t1_squash_ex0", redirect_valid, 0);
      chk("t1_upd_pc", upd_bus.upd_pc, 8'h10);
      chk("t1_upd_target", upd_bus.upd_target, 8'h20);
      chk("t1_upd_taken", upd_bus.upd_taken, 1);
      chk("t1_upd_hit", upd_bus.upd_hit, 0);
      chk("t1_mispred_cnt", mispred_cnt, 1);
      tick; #2;
      chk("t1_squash_ex1", redirect_valid, 0);
      chk("t1_no_push", upd_bus.upd_valid, 0);

      // Correctly predicted taken branch.
      issue(8'h10, 1, 8'h20, 1, 2'b01, 1, 8'h20);
      chk("t2_no_redirect", redirect_valid, 0);
      tick; exin(2'b00, 0, 8'h00); #2;
      chk("t2_upd_valid", upd_bus.upd_valid, 1);
      chk("t2_upd_hit", upd_bus.upd_hit, 1);
      chk("t2_upd_taken", upd_bus.upd_taken, 1);
      tick;

      // jalr wrong target, fall-through wrap, aliased non-branch hit.
      issue(8'h30, 1, 8'h40, 1, 2'b11, 0, 8'h44);
      chk("t3_jalr_redirect_pc", redirect_pc, 8'h44);
      tick; exin(2'b00, 0, 8'h00); tick;
      issue(8'hff, 1, 8'h80, 0, 2'b01, 0, 8'h80);
      chk("t3_wrap_redirect_valid", redirect_valid, 1);
      chk("t3_wrap_redirect_pc", redirect_pc, 8'h00);
      tick; exin(2'b00, 0, 8'h00); #2;
      chk("t3_wrap_upd_taken", upd_bus.upd_taken, 0);
      tick;
      issue(8'h50, 1, 8'h60, 1, 2'b00, 0, 8'h00);
      chk("t3_alias_redirect_pc", redirect_pc, 8'h51);
      tick; #2;
      chk("t3_alias_upd_pc", upd_bus.upd_pc, 8'h50);
      chk("t3_alias_upd_hit", upd_bus.upd_hit, 1);
      chk("t3_branch_cnt", branch_cnt, 4);
      chk("t3_mispred_cnt", mispred_cnt, 4);
      tick;

      // Back-pressure: third packet dropped, then ordered drain.
      upd_bus.upd_ready = 1'b0;
      fetch(8'h01, 0, 8'h00, 0); tick;
      fetch(8'h02, 0, 8'h00, 0); tick;
      fetch(8'h03, 0, 8'h00, 0); exin(2'b01, 0, 8'h70); tick;
      nofetch; tick; tick;
      exin(2'b00, 0, 8'h00); #2;
      chk("t4_drop_cnt", drop_cnt, 1);
      chk("t4_head0", upd_bus.upd_pc, 8'h01);
      upd_bus.upd_ready = 1'b1;
      tick; #2;
      chk("t4_head1", upd_bus.upd_pc, 8'h02);
      tick; #2;
      chk("t4_empty", upd_bus.upd_valid, 0);

      // Full queue with push and pop in the same cycle: nothing dropped.
      upd_bus.upd_ready = 1'b0;
      fetch(8'h04, 0, 8'h00, 0); tick;
      fetch(8'h05, 0, 8'h00, 0); tick;
      fetch(8'h06, 0, 8'h00, 0); exin(2'b01, 0, 8'h70); tick;
      nofetch; tick;
      upd_bus.upd_ready = 1'b1; #2;
      chk("t4_full_head", upd_bus.upd_pc, 8'h04);
      tick; exin(2'b00, 0, 8'h00); #2;
      chk("t4_pp_drop_cnt", drop_cnt, 1);
      chk("t4_pp_head5", upd_bus.upd_pc, 8'h05);
      tick; #2;
      chk("t4_pp_head6", upd_bus.upd_pc, 8'h06);
      chk("t4_branch_cnt", branch_cnt, 10);
      tick;

      // Three stalled cycles with a branch in EX: counted once, after the stall.
      fetch(8'h40, 0, 8'h00, 0); tick;
      nofetch; tick;
      exin(2'b01, 0, 8'h70); stall = 1'b1; #2;
      chk("t5_stall_cnt0", branch_cnt, 10);
      tick; tick; #2;
      chk("t5_stall_cnt2", branch_cnt, 10);
      chk("t5_stall_no_push", upd_bus.upd_valid, 0);
      tick; stall = 1'b0;
      tick; exin(2'b00, 0, 8'h00); #2;
      chk("t5_post_stall_cnt", branch_cnt, 11);
      chk("t5_post_stall_upd", upd_bus.upd_pc, 8'h40);
      tick;

      // Reset with a full queue and a mispredicting branch in EX.
      upd_bus.upd_ready = 1'b0;
      fetch(8'h07, 0, 8'h00, 0); tick;
      fetch(8'h08, 0, 8'h00, 0); tick;
      fetch(8'h09, 1, 8'h90, 0); exin(2'b01, 0, 8'h70); tick;
      nofetch; tick;
      rst = 1'b1; #2;
      chk("t5_rst_no_redirect", redirect_valid, 0);
      chk("t5_pre_rst_cnt", branch_cnt, 13);
      chk("t5_pre_rst_full", upd_bus.upd_valid, 1);
      tick; rst = 1'b0; exin(2'b00, 0, 8'h00); #2;
      chk("t5_rst_upd_valid", upd_bus.upd_valid, 0);
      chk("t5_rst_branch_cnt", branch_cnt, 0);
      chk("t5_rst_mispred_cnt", mispred_cnt, 0);
      chk("t5_rst_drop_cnt", drop_cnt, 0);
      upd_bus.upd_ready = 1'b1;
      tick; tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
